multi_channel_led_debugger: RTL and testbench

- Multi-channel successor to the single-stream LED debug queue.
- Each of CHANNELS ready/valid debug streams is buffered in its own FIFO.
- The operator selects one channel and steps its entries onto the LEDs, either manually (one entry per display_next press) or automatically (one entry every AUTO_PERIOD cycles).
- Sits between internal debug taps and the board LEDs/buttons/switches.

---
 rtl/multi_channel_led_debugger.sv | 139 +++++++++++++
 tb/tb_multi_channel_led_debugger.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_led_debugger.sv
// Buffers CHANNELS debug streams in per-channel FIFOs and steps the selected channel onto the LEDs.
// Define LED_DEBUGGER_DROP_ON_FULL_EN to drop beats on a full FIFO and report them on overflow.
module multi_channel_led_debugger #(
  parameter int unsigned DATA_WIDTH           = 8,
  parameter int unsigned CHANNELS             = 4,
  parameter int unsigned CHANNEL_BITS         = 2,
  parameter int unsigned MAX_QUEUE_DEPTH_BITS = 4,
  parameter int unsigned AUTO_PERIOD          = 50000000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]            valid_in,
  output logic [CHANNELS-1:0]            ready_in,
  input  logic [CHANNEL_BITS-1:0]        channel_select,
  input  logic                           display_next,
  input  logic                           auto_mode,
  output logic [CHANNELS-1:0]            pending,
  output logic [DATA_WIDTH-1:0]          leds
`ifdef LED_DEBUGGER_DROP_ON_FULL_EN
  ,
  output logic [CHANNELS-1:0]            overflow
`endif
);

  localparam int unsigned Depth = 1 << MAX_QUEUE_DEPTH_BITS;
  localparam int unsigned PtrW  = MAX_QUEUE_DEPTH_BITS;
  localparam int unsigned CntW  = $clog2(AUTO_PERIOD);

  typedef logic [DATA_WIDTH-1:0] data_t;

  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  data_t               head [CHANNELS];
  data_t               sel_data;

  logic                display_next_q;
  logic [CntW-1:0]     auto_cnt_q, auto_cnt_d;
  logic                auto_wrap;
  logic                req;

  // Per-channel circular FIFO; capacity is exactly Depth entries.
  for (genvar g = 0; g < CHANNELS; g++) begin : gen_fifo
    data_t           mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;

    assign full[g]    = (count_q == (PtrW+1)'(Depth));
    assign pending[g] = (count_q != '0);
    assign head[g]    = mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push[g]) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop[g]) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        if (push[g] && !pop[g]) begin
          count_q <= count_q + 1'b1;
        end else if (!push[g] && pop[g]) begin
          count_q <= count_q - 1'b1;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (push[g]) begin
        mem_q[wr_ptr_q] <= data_in[g*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A full FIFO never accepts, even when it is popped in the same cycle.
  assign push = valid_in & ~full;

`ifdef LED_DEBUGGER_DROP_ON_FULL_EN
  assign ready_in = '1;

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= '0;
    end else begin
      overflow <= overflow | (valid_in & full);
    end
  end
`else
  assign ready_in = ~full;
`endif

  assign auto_wrap = (auto_cnt_q == CntW'(AUTO_PERIOD - 1));

  always_comb begin
    auto_cnt_d = '0;
    if (auto_mode && !auto_wrap) begin
      auto_cnt_d = auto_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      display_next_q <= 1'b0;
      auto_cnt_q     <= '0;
    end else begin
      display_next_q <= display_next;
      auto_cnt_q     <= auto_cnt_d;
    end
  end

  // Button edges are ignored while timed stepping is active.
  assign req = auto_mode ? auto_wrap : (display_next & ~display_next_q);

  // Out-of-range selects match no channel, so they pop nothing.
  always_comb begin
    pop      = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (req && (channel_select == CHANNEL_BITS'(i)) && pending[i]) begin
        pop[i]   = 1'b1;
        sel_data = head[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      leds <= '0;
    end else if (|pop) begin
      leds <= sel_data;
    end
  end

endmodule

// File: tb/tb_multi_channel_led_debugger.sv
// Randomised and directed bench for multi_channel_led_debugger against a queue-based model.
module tb_multi_channel_led_debugger;

  localparam int DW = 8;
  localparam int CH = 4;
  localparam int CB = 3;
  localparam int QB = 2;
  localparam int D  = 4;
  localparam int P  = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic [CH*DW-1:0]    data_in;
  logic [CH-1:0]       valid_in;
  logic [CH-1:0]       ready_in;
  logic [CB-1:0]       channel_select;
  logic                display_next;
  logic                auto_mode;
  logic [CH-1:0]       pending;
  logic [DW-1:0]       leds;
`ifdef LED_DEBUGGER_DROP_ON_FULL_EN
  logic [CH-1:0]       overflow;
  localparam bit DropMode = 1'b1;
`else
  localparam bit DropMode = 1'b0;
`endif

  multi_channel_led_debugger #(
    .DATA_WIDTH          (DW),
    .CHANNELS            (CH),
    .CHANNEL_BITS        (CB),
    .MAX_QUEUE_DEPTH_BITS(QB),
    .AUTO_PERIOD         (P)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .ready_in      (ready_in),
    .channel_select(channel_select),
    .display_next  (display_next),
    .auto_mode     (auto_mode),
    .pending       (pending),
    .leds          (leds)
`ifdef LED_DEBUGGER_DROP_ON_FULL_EN
    ,
    .overflow      (overflow)
`endif
  );

  always #5 clock = ~clock;

  int assertions = 0;
  int failures   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel, the displayed value and the step-request rules.
  logic [DW-1:0] mq [CH][$];
  logic [DW-1:0] m_leds;
  logic          m_prev;
  int            m_run;
  logic [CH-1:0] m_ovf;
  logic [CH-1:0] m_acc;
  bit            m_req;
  bit            started = 1'b0;

  function automatic logic [CH-1:0] model_pending();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (mq[i].size() > 0);
    return r;
  endfunction

  function automatic logic [CH-1:0] model_ready();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = DropMode ? 1'b1 : (mq[i].size() < D);
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) mq[i].delete();
      m_leds  = '0;
      m_prev  = 1'b0;
      m_run   = 0;
      m_ovf   = '0;
      started = 1'b1;
    end else begin
      for (int i = 0; i < CH; i++) begin
        m_acc[i] = valid_in[i] && (mq[i].size() < D);
        if (DropMode && valid_in[i] && (mq[i].size() == D)) m_ovf[i] = 1'b1;
      end
      if (auto_mode) begin
        m_run++;
        m_req = ((m_run % P) == 0);
      end else begin
        m_run = 0;
        m_req = display_next && !m_prev;
      end
      m_prev = display_next;
      if (m_req && (int'(channel_select) < CH)) begin
        if (mq[channel_select].size() > 0) m_leds = mq[channel_select].pop_front();
      end
      for (int i = 0; i < CH; i++) begin
        if (m_acc[i]) mq[i].push_back(data_in[i*DW +: DW]);
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      check("model_leds", 32'(leds), 32'(m_leds));
      check("model_pending", 32'(pending), 32'(model_pending()));
      check("model_ready_in", 32'(ready_in), 32'(model_ready()));
`ifdef LED_DEBUGGER_DROP_ON_FULL_EN
      check("model_overflow", 32'(overflow), 32'(m_ovf));
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input int ch, input logic [DW-1:0] d);
    valid_in[ch]          = 1'b1;
    data_in[ch*DW +: DW]  = d;
    tick();
    valid_in[ch]          = 1'b0;
  endtask

  task automatic press();
    display_next = 1'b1;
    tick();
    display_next = 1'b0;
    tick();
  endtask

  int accepted;

  initial begin
    reset          = 1'b1;
    valid_in       = '0;
    data_in        = '0;
    channel_select = '0;
    display_next   = 1'b0;
    auto_mode      = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_leds", 32'(leds), 32'h00);
    check("reset_pending", 32'(pending), 32'h0);
    check("reset_ready_in", 32'(ready_in), 32'hF);

    // Manual step with the button held.
    push(1, 8'hA5);
    push(1, 8'h3C);
    channel_select = 3'd1;
    display_next   = 1'b1;
    tick();
    check("hold_first", 32'(leds), 32'hA5);
    repeat (9) tick();
    check("hold_no_repeat", 32'(leds), 32'hA5);
    check("hold_pending1", 32'(pending[1]), 32'h1);
    display_next = 1'b0;
    tick();
    display_next = 1'b1;
    tick();
    check("second_press", 32'(leds), 32'h3C);
    check("second_pending1", 32'(pending[1]), 32'h0);
    display_next = 1'b0;
    tick();

    // Empty channel and out-of-range selects.
    channel_select = 3'd2;
    press();
    check("empty_press", 32'(leds), 32'h3C);
    push(2, 8'h11);
    tick();
    tick();
    check("late_data_not_shown", 32'(leds), 32'h3C);
    check("late_data_pending2", 32'(pending[2]), 32'h1);
    channel_select = 3'd5;
    press();
    check("out_of_range5", 32'(leds), 32'h3C);
    channel_select = 3'd4;
    press();
    check("out_of_range4", 32'(leds), 32'h3C);
    check("out_of_range_keeps2", 32'(pending[2]), 32'h1);

    // Timed stepping, with button activity that must be ignored.
    channel_select = 3'd0;
    push(0, 8'h01);
    push(0, 8'h02);
    push(0, 8'h03);
    auto_mode = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      display_next = n[0];
      tick();
      if (n == 3)  check("auto_before_first", 32'(leds), 32'h3C);
      if (n == 4)  check("auto_first", 32'(leds), 32'h01);
      if (n == 7)  check("auto_hold", 32'(leds), 32'h01);
      if (n == 8)  check("auto_second", 32'(leds), 32'h02);
      if (n == 12) check("auto_third", 32'(leds), 32'h03);
      if (n == 16) check("auto_empty_hold", 32'(leds), 32'h03);
    end
    auto_mode    = 1'b0;
    display_next = 1'b0;
    tick();

`ifndef LED_DEBUGGER_DROP_ON_FULL_EN
    // Backpressure: ch3 takes exactly D beats.
    channel_select = 3'd3;
    accepted = 0;
    for (int k = 0; k < 10; k++) begin
      if (!ready_in[3]) break;
      valid_in[3]       = 1'b1;
      data_in[3*DW +: DW] = 8'(8'h40 + k);
      accepted++;
      tick();
    end
    valid_in[3] = 1'b0;
    check("full_accepted", 32'(accepted), 32'(D));
    check("full_ready3", 32'(ready_in[3]), 32'h0);
    for (int k = 0; k < D; k++) begin
      press();
      check("full_pop_order", 32'(leds), 32'(8'h40 + k));
    end
    check("full_drained3", 32'(pending[3]), 32'h0);
    check("full_other2", 32'(pending[2]), 32'h1);
    check("full_ready3_again", 32'(ready_in[3]), 32'h1);
`else
    // Drop-on-full: extra beat is discarded and flagged.
    channel_select = 3'd3;
    for (int k = 0; k < D; k++) push(3, 8'(8'h50 + k));
    check("drop_ready3", 32'(ready_in[3]), 32'h1);
    check("drop_ovf_before", 32'(overflow[3]), 32'h0);
    push(3, 8'hFF);
    check("drop_ovf_set", 32'(overflow[3]), 32'h1);
    for (int k = 0; k < D; k++) begin
      press();
      check("drop_pop_order", 32'(leds), 32'(8'h50 + k));
    end
    press();
    check("drop_ff_never_shown", 32'(leds), 32'h53);
    check("drop_ovf_sticky", 32'(overflow[3]), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("drop_ovf_reset", 32'(overflow), 32'h0);
`endif

    // Random traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      valid_in = 4'($urandom);
      data_in  = $urandom;
      if ($urandom_range(0, 15) == 0) channel_select = 3'($urandom);
      if ($urandom_range(0, 3) == 0) display_next = ~display_next;
      if ($urandom_range(0, 149) == 0) auto_mode = ~auto_mode;
      reset = ($urandom_range(0, 699) == 0);
      tick();
    end
    reset    = 1'b0;
    valid_in = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
